// File: rtl/id_pkg.sv
// Shared decode-stage definitions: two-word opcodes, the FSM state type and the
// predicate that identifies immediate-carrying instructions.
package id_pkg;

  localparam logic [4:0] OP_LDM  = 5'b11000;
  localparam logic [4:0] OP_IADD = 5'b11001;

  typedef enum logic {S_DECODE, S_IMM} id_state_e;

  function automatic logic is_two_word(input logic [4:0] opcode);
    return (opcode == OP_LDM) || (opcode == OP_IADD);
  endfunction

endpackage

// File: rtl/id_decode_pipe_if.sv
// Fetch-side and EX-side handshakes of the decode stage. master drives instruction words
// and consumes bundles; slave is the decode stage itself.
interface id_decode_pipe_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_opcode;
  logic [AW-1:0]    out_rs;
  logic [AW-1:0]    out_rd;
  logic [WIDTH-1:0] out_op1;
  logic [WIDTH-1:0] out_op2;
  logic [WIDTH-1:0] out_imm;
  logic             out_two_word;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rd, out_op1, out_op2, out_imm,
           out_two_word
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rd, out_op1, out_op2, out_imm,
           out_two_word
  );
endinterface

// File: rtl/id_regfile.sv
// NUM_REGS x WIDTH register file: two asynchronous reads, one synchronous write.
// Define ID_WB_BYPASS_EN to forward a same-cycle write to the read ports.
module id_regfile #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
  output logic [WIDTH-1:0]            rdata_a,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
  output logic [WIDTH-1:0]            rdata_b
);
  logic [WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
`else
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
`endif

endmodule

// File: rtl/id_decode_pipe.sv
// Instruction-decode stage: assembles one/two-word instructions, reads operands and holds
// a registered bundle for EX. Optional same-cycle WB forwarding via ID_WB_BYPASS_EN.
module id_decode_pipe
  import id_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        load_use,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [WIDTH-1:0]            wb_data,
  id_decode_pipe_if.slave             bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  id_state_e        state_q;
  logic [WIDTH-1:0] first_q;
  logic             out_valid_q;
  logic [4:0]       opcode_q;
  logic [AW-1:0]    rs_q, rd_q;
  logic [WIDTH-1:0] op1_q, op2_q, imm_q;
  logic             two_word_q;

  logic             in_ready, accept, load, start_two;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] dec_word;
  logic [AW-1:0]    rs_addr, rd_addr;
  logic [WIDTH-1:0] rs_data, rd_data;

  assign in_ready  = !flush && !load_use && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign in_op     = bus.in_instr[WIDTH-1 -: 5];
  assign start_two = accept && (state_q == S_DECODE) && is_two_word(in_op);
  assign load      = accept && !start_two;

  // In S_IMM the incoming word is the immediate; fields come from the latched first word.
  assign dec_word = (state_q == S_IMM) ? first_q : bus.in_instr;
  assign rs_addr  = dec_word[WIDTH-6 -: AW];
  assign rd_addr  = dec_word[WIDTH-6-AW -: AW];

  id_regfile #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .rdata_a (rs_data),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_DECODE;
      first_q     <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs_q        <= '0;
      rd_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      two_word_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= S_DECODE;
      first_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (start_two) begin
        first_q <= bus.in_instr;
        state_q <= S_IMM;
      end else if (load) begin
        state_q    <= S_DECODE;
        opcode_q   <= dec_word[WIDTH-1 -: 5];
        rs_q       <= rs_addr;
        rd_q       <= rd_addr;
        op1_q      <= rs_data;
        op2_q      <= rd_data;
        two_word_q <= (state_q == S_IMM);
        imm_q      <= (state_q == S_IMM) ? bus.in_instr
                                         : {{(WIDTH-8){1'b0}}, bus.in_instr[7:0]};
      end
      if (load) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = opcode_q;
  assign bus.out_rs       = rs_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_op1      = op1_q;
  assign bus.out_op2      = op2_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_two_word = two_word_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: directed scenarios plus randomized traffic against a
// bundle-level reference model (honours ID_WB_BYPASS_EN).
module tb_id_decode_pipe;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NUM_REGS = 8;

  logic        clk, rst, flush, load_use, wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  int n_checks = 0;
  int n_fail   = 0;

  id_decode_pipe_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus ();

  id_decode_pipe #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load_use (load_use),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 0; load_use = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 1;
    tick(); tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_imm !== 16'h0) begin n_fail++; $display("FAIL reset_imm got=%h exp=0", bus.out_imm); end
    n_checks++; if (bus.out_opcode !== 5'h0) begin n_fail++; $display("FAIL reset_opcode got=%h exp=0", bus.out_opcode); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wb_en = 1; wb_addr = 3; wb_data = 16'h1234; tick();
    wb_addr = 5; wb_data = 16'h00FF; tick();
    wb_en = 0;
    bus.in_valid = 1; bus.in_instr = 16'h0D60; bus.out_ready = 0; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_op1 !== 16'h00FF) begin n_fail++; $display("FAIL basic_op1 got=%h exp=00ff", bus.out_op1); end
    n_checks++; if (bus.out_op2 !== 16'h1234) begin n_fail++; $display("FAIL basic_op2 got=%h exp=1234", bus.out_op2); end
    n_checks++; if (bus.out_two_word !== 1'b0) begin n_fail++; $display("FAIL basic_tw got=%b exp=0", bus.out_two_word); end
    n_checks++; if ({bus.out_opcode, bus.out_rs, bus.out_rd} !== {5'd1, 3'd5, 3'd3}) begin n_fail++; $display("FAIL basic_fields got=%h/%h/%h exp=1/5/3", bus.out_opcode, bus.out_rs, bus.out_rd); end
    n_checks++; if (bus.out_imm !== 16'h0060) begin n_fail++; $display("FAIL basic_imm got=%h exp=0060", bus.out_imm); end
    bus.out_ready = 1; tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_ldm();
    bus.out_ready = 1; bus.in_valid = 1; bus.in_instr = 16'hC200; tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ldm_first got=%b exp=0", bus.out_valid); end
    bus.in_instr = 16'hBEEF; tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ldm_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_opcode !== 5'b11000) begin n_fail++; $display("FAIL ldm_opcode got=%b exp=11000", bus.out_opcode); end
    n_checks++; if (bus.out_rs !== 3'd2) begin n_fail++; $display("FAIL ldm_rs got=%0d exp=2", bus.out_rs); end
    n_checks++; if (bus.out_imm !== 16'hBEEF) begin n_fail++; $display("FAIL ldm_imm got=%h exp=beef", bus.out_imm); end
    n_checks++; if (bus.out_two_word !== 1'b1) begin n_fail++; $display("FAIL ldm_tw got=%b exp=1", bus.out_two_word); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_instr = 16'h0D60; tick();
    bus.in_instr = 16'h1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      tick();
      n_checks++; if ({bus.out_valid, bus.out_imm, bus.out_op1} !== {1'b1, 16'h0060, 16'h00FF}) begin n_fail++; $display("FAIL bp_stable cyc=%0d got=%b/%h/%h exp=1/0060/00ff", c, bus.out_valid, bus.out_imm, bus.out_op1); end
    end
    bus.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      bus.in_instr = 16'h1000 + 16'(k);
      tick();
      n_checks++; if ({bus.out_valid, bus.out_imm} !== {1'b1, 16'(k)}) begin n_fail++; $display("FAIL b2b k=%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_imm, k); end
    end
    bus.in_valid = 0; tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1; bus.in_valid = 1; bus.in_instr = 16'hC200; tick();
    flush = 1; bus.in_instr = 16'h0D60; #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    flush = 0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    tick();
    bus.in_valid = 0;
    n_checks++; if ({bus.out_valid, bus.out_opcode, bus.out_two_word} !== {1'b1, 5'd1, 1'b0}) begin n_fail++; $display("FAIL flush_redecode got=%b/%b/%b exp=1/00001/0", bus.out_valid, bus.out_opcode, bus.out_two_word); end
    tick();
  endtask

  task automatic test_load_use();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_instr = 16'h0D60; tick();
    load_use = 1; bus.out_ready = 1; #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%b exp=0", bus.out_valid); end
    load_use = 0; bus.in_valid = 0; tick();
  endtask

  task automatic test_wb_bypass();
    logic [15:0] exp_op1;
`ifdef ID_WB_BYPASS_EN
    exp_op1 = 16'hAAAA;
`else
    exp_op1 = 16'h00FF;
`endif
    bus.out_ready = 1; bus.in_valid = 1; bus.in_instr = 16'h0D60;
    wb_en = 1; wb_addr = 5; wb_data = 16'hAAAA; tick();
    wb_en = 0;
    n_checks++; if (bus.out_op1 !== exp_op1) begin n_fail++; $display("FAIL bypass_op1 got=%h exp=%h", bus.out_op1, exp_op1); end
    n_checks++; if (bus.out_op2 !== 16'h1234) begin n_fail++; $display("FAIL bypass_op2 got=%h exp=1234", bus.out_op2); end
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_op1 !== 16'hAAAA) begin n_fail++; $display("FAIL bypass_after got=%h exp=aaaa", bus.out_op1); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1; bus.in_valid = 1; bus.in_instr = 16'hC200; tick();
    bus.in_valid = 0; rst = 0; #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
    rst = 1;
    tick();
    bus.in_valid = 1; bus.in_instr = 16'h0D60; tick();
    bus.in_valid = 0;
    n_checks++; if ({bus.out_valid, bus.out_opcode, bus.out_two_word, bus.out_op1} !== {1'b1, 5'd1, 1'b0, 16'h0}) begin n_fail++; $display("FAIL rstmid_decode got=%b/%b/%b/%h exp=1/00001/0/0000", bus.out_valid, bus.out_opcode, bus.out_two_word, bus.out_op1); end
    tick();
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] regs [8], input int a,
                                             input logic we, input int wa, input logic [15:0] wd);
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return regs[a];
  endfunction

  task automatic test_random();
    logic [15:0] m_regs [8];
    logic        m_valid, m_pend, m_tw;
    logic [15:0] m_first, m_op1, m_op2, m_imm, w, src, wd;
    int          m_opc, m_rs, m_rd, wa;
    logic        fl, lu, iv, orr, we, exp_rdy, acc, two;
    rst = 0; #2; rst = 1;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_valid = 0; m_pend = 0; m_first = 0; m_tw = 0;
    m_opc = 0; m_rs = 0; m_rd = 0; m_op1 = 0; m_op2 = 0; m_imm = 0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      fl  = ($urandom_range(0, 19) == 0);
      lu  = ($urandom_range(0, 9) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 2) == 0);
      wa  = $urandom_range(0, 7);
      wd  = 16'($urandom);
      w   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w = (w & 16'h07FF) | ($urandom_range(0, 1) ? 16'hC000 : 16'hC800);
      flush = fl; load_use = lu; bus.in_valid = iv; bus.in_instr = w; bus.out_ready = orr;
      wb_en = we; wb_addr = 3'(wa); wb_data = wd;
      #1;
      exp_rdy = !fl && !lu && (!m_valid || orr);
      n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy); end
      acc = iv && exp_rdy;
      two = ((w >> 11) == 16'h18) || ((w >> 11) == 16'h19);
      if (fl) begin
        m_valid = 0; m_pend = 0;
      end else if (acc && !m_pend && two) begin
        m_pend = 1; m_first = w;
        if (orr) m_valid = 0;
      end else if (acc) begin
        src   = m_pend ? m_first : w;
        m_opc = int'(src >> 11);
        m_rs  = int'((src >> 8) & 16'h7);
        m_rd  = int'((src >> 5) & 16'h7);
        m_op1 = model_read(m_regs, m_rs, we, wa, wd);
        m_op2 = model_read(m_regs, m_rd, we, wa, wd);
        m_imm = m_pend ? w : (w & 16'h00FF);
        m_tw  = m_pend;
        m_pend = 0; m_valid = 1;
      end else if (orr) begin
        m_valid = 0;
      end
      if (we) m_regs[wa] = wd;
      tick();
      n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if ({bus.out_opcode, bus.out_rs, bus.out_rd, bus.out_op1, bus.out_op2, bus.out_imm, bus.out_two_word}
            !== {5'(m_opc), 3'(m_rs), 3'(m_rd), m_op1, m_op2, m_imm, m_tw}) begin
          n_fail++;
          $display("FAIL rnd_bundle cyc=%0d got=%h/%0d/%0d/%h/%h/%h/%b exp=%h/%0d/%0d/%h/%h/%h/%b", cyc,
                   bus.out_opcode, bus.out_rs, bus.out_rd, bus.out_op1, bus.out_op2, bus.out_imm,
                   bus.out_two_word, m_opc, m_rs, m_rd, m_op1, m_op2, m_imm, m_tw);
        end
      end
    end
    flush = 0; load_use = 0; wb_en = 0; bus.in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ldm();
    test_back_to_back();
    test_flush();
    test_load_use();
    test_wb_bypass();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
